// File: rtl/nabp_shifter.sv
// nabp_shifter: kicks the mapper, issues IMAGE_SIZE shift beats, then signals done;
// forwards line-buffer samples to the PE chain one cycle after each beat.
module nabp_shifter #(
  parameter int IMAGE_SIZE = 256,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sc_kick,
  output logic                  sc_done,
  output logic                  sh_kick,
  input  logic                  mp_ack,
  output logic                  sh_shift_en,
  output logic                  sh_done,
  input  logic [DATA_WIDTH-1:0] rm_data,
  input  logic                  pe_ready,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic                  pe_valid
);
  localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [1:0] IDLE = 2'd0, KICK = 2'd1, SHIFT = 2'd2, DRAIN = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);
  logic [1:0]            r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_beat;
  assign w_beat = (r_state == SHIFT) && pe_ready;
  always_comb begin
    w_next = r_state == IDLE  ? (sc_kick ? KICK : IDLE) :
             r_state == KICK  ? (mp_ack ? SHIFT : KICK) :
             r_state == SHIFT ? ((w_beat && r_cnt == LAST) ? DRAIN : SHIFT) :
                                IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_beat;
      if (r_state == KICK) r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (w_beat) r_data <= rm_data;
    end
  end
  assign sh_kick     = r_state == KICK;
  assign sh_shift_en = w_beat;
  assign sh_done     = r_state == DRAIN;
  assign sc_done     = r_state == DRAIN;
  assign pe_valid    = r_valid;
  assign pe_data     = r_data;
endmodule

// File: tb/tb_nabp_shifter.sv
// tb_nabp_shifter: randomized line sequencing against a scoreboard of beats, samples and done events.
module tb_nabp_shifter;
  localparam int N = 8, DW = 16;
  logic clk = 1'b0, reset_n = 1'b0, sc_kick = 1'b0, mp_ack = 1'b0, pe_ready = 1'b0;
  logic [DW-1:0] rm_data = '0;
  logic sc_done, sh_kick, sh_shift_en, sh_done, pe_valid;
  logic [DW-1:0] pe_data;
  int n_chk = 0, n_err = 0;
  int ack_delay = 1, ready_mode = 0, rp = 0, base = 100, b2b = 0;
  int kick_run = 0, beats = 0, line_beats = 0, dones = 0, kick_lines = 0;
  int cyc = 0, kick_t = 0, last_beat_t = 0, last_done_t = 0;
  logic p_kick = 0, p_shift = 0, p_done = 0;
  logic [DW-1:0] p_data = '0;
  logic [DW-1:0] exp_q[$];
  always #5 clk = ~clk;
  nabp_shifter #(.IMAGE_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .sc_kick(sc_kick), .sc_done(sc_done),
    .sh_kick(sh_kick), .mp_ack(mp_ack), .sh_shift_en(sh_shift_en), .sh_done(sh_done),
    .rm_data(rm_data), .pe_ready(pe_ready), .pe_data(pe_data), .pe_valid(pe_valid)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic clear_model();
    mp_ack = 0; kick_run = 0; line_beats = 0; exp_q.delete();
    p_kick = 0; p_shift = 0; p_done = 0; p_data = '0;
  endtask
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (p_done) begin mp_ack = 0; kick_run = 0; end
    else if (p_kick) begin kick_run++; if (kick_run >= ack_delay) mp_ack = 1; end
    pe_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (rp % 3 == 0) : 1'($urandom_range(0, 1));
    rp++;
    rm_data = pe_ready ? DW'(base + line_beats) : DW'($urandom);
    #1;
    check("exclusive", 64'(sh_kick) + 64'(sh_shift_en) + 64'(sh_done) <= 1, 1);
    check("sc_done_vs_sh_done", sc_done, sh_done);
    check("valid_latency", pe_valid, p_shift);
    if (pe_valid) check("pe_data", pe_data, exp_q.size() > 0 ? exp_q.pop_front() : ~pe_data);
    else check("pe_data_hold", pe_data, p_data);
    if (sh_shift_en) begin
      check("beat_needs_ready", pe_ready, 1);
      check("beat_needs_ack", mp_ack, 1);
      exp_q.push_back(rm_data);
      line_beats++; beats++; last_beat_t = cyc;
    end
    if (sh_kick && !p_kick) begin
      kick_lines++; kick_t = cyc;
      if (b2b && kick_lines > 1) check("b2b_gap", cyc - last_done_t, 2);
    end
    if (sh_done) begin
      dones++;
      check("line_beats", line_beats, N);
      check("drain_after_last_beat", cyc - last_beat_t, 1);
      check("queue_drained", exp_q.size(), 0);
      if (ready_mode == 0) check("kick_to_done_gap", cyc - kick_t, 9 + ack_delay);
      line_beats = 0; last_done_t = cyc;
    end
    p_kick = sh_kick; p_shift = sh_shift_en; p_done = sh_done; p_data = pe_data;
  endtask
  task automatic run_line(int ad, int mode, int mid_kick, int abort_at);
    int d0, k0, t;
    d0 = dones; k0 = kick_lines; t = 0;
    ack_delay = ad; ready_mode = mode; rp = 0;
    sc_kick = 1; step(); sc_kick = 0;
    while (dones == d0 && t < 300) begin
      if (abort_at > 0 && line_beats == abort_at) break;
      sc_kick = (mid_kick != 0 && line_beats == 3) ? 1'b1 : 1'b0;
      step(); t++;
    end
    sc_kick = 0;
    if (abort_at > 0) begin
      check("abort_reached", line_beats, abort_at);
      reset_n = 0; #1;
      check("abort_sh_kick", sh_kick, 0);
      check("abort_shift_en", sh_shift_en, 0);
      check("abort_sh_done", sh_done, 0);
      check("abort_sc_done", sc_done, 0);
      check("abort_pe_valid", pe_valid, 0);
      check("abort_pe_data", pe_data, 0);
      clear_model();
      repeat (2) step();
      reset_n = 1;
      repeat (3) step();
      check("abort_no_done", dones, d0);
    end else begin
      check("line_timeout", dones > d0, 1);
      repeat (4) step();
      check("single_done", dones, d0 + 1);
      check("no_extra_line", kick_lines, k0 + 1);
    end
  endtask
  initial begin
    #2;
    check("rst_sh_kick", sh_kick, 0);
    check("rst_shift_en", sh_shift_en, 0);
    check("rst_done", sc_done | sh_done, 0);
    check("rst_pe_valid", pe_valid, 0);
    check("rst_pe_data", pe_data, 0);
    repeat (2) step();
    reset_n = 1;
    repeat (3) step();
    check("idle_no_kick", kick_lines, 0);
    base = 100;
    run_line(1, 0, 0, 0);
    base = $urandom_range(0, 60000);
    run_line(5, 0, 0, 0);
    run_line(1, 1, 0, 0);
    run_line(2, 0, 1, 0);
    run_line(1, 0, 0, 4);
    run_line(1, 0, 0, 0);
    begin
      int d0, b0, t;
      d0 = dones; b0 = beats; t = 0; b2b = 1; kick_lines = 0;
      ack_delay = 1; ready_mode = 0;
      sc_kick = 1;
      while (dones < d0 + 3 && t < 300) begin step(); t++; end
      sc_kick = 0;
      repeat (4) step();
      b2b = 0;
      check("b2b_dones", dones, d0 + 3);
      check("b2b_beats", beats, b0 + 3 * N);
      check("b2b_lines", kick_lines, 3);
    end
    for (int i = 0; i < 20; i++) begin
      base = $urandom_range(0, 60000);
      run_line($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 1), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
